onehot_ch_sequencer: RTL and testbench

Receive side of the channel-select path. Accepts a one-hot channel vector plus valid from the priority encoder stage and checks that exactly one bit is set. It converts the vector to a binary channel index and holds that channel active for a programmable dwell time, then pulses completion. Illegal vectors (zero-hot or multi-hot) are rejected and flagged with sticky error bits. The result drives the per-channel mux and the downstream timing logic.

---
 rtl/onehot_ch_sequencer.sv | 146 ++++++++++++++
 tb/tb_onehot_ch_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/onehot_ch_sequencer.sv
// One-hot channel request sequencer: validates a one-hot vector, converts it to a
// binary index, holds the channel for a programmable dwell, then pulses completion.
module onehot_ch_sequencer #(
  parameter int unsigned N_CH = 16,
  parameter int unsigned DW_W = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N_CH-1:0]         hot_one_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [DW_W-1:0]         dwell_i,
  input  logic                    abort_i,
  input  logic                    err_clr_i,
  output logic [$clog2(N_CH)-1:0] ch_idx_o,
  output logic [N_CH-1:0]         ch_sel_o,
  output logic                    ch_valid_o,
  output logic                    ch_done_o,
  output logic                    err_zero_o,
  output logic                    err_multi_o
);

  localparam int unsigned IDX_W = $clog2(N_CH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DW_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [N_CH-1:0]   sel_q, sel_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              err_zero_q, err_zero_d;
  logic              err_multi_q, err_multi_d;

  logic              hot_zero;
  logic              hot_multi;
  logic [IDX_W-1:0]  enc_idx;
  logic              accept;

  // Clearing the lowest set bit leaves something only when two or more bits are set.
  assign hot_zero  = ~|hot_one_i;
  assign hot_multi = |(hot_one_i & (hot_one_i - N_CH'(1)));
  assign accept    = valid_i & ready_q;

  // OR-encoder; only consulted when the vector is known to be one-hot.
  always_comb begin
    enc_idx = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (hot_one_i[i]) begin
        enc_idx = enc_idx | IDX_W'(i);
      end
    end
  end

  // Next-state, counter, channel and error-flag logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    sel_d       = sel_q;
    ready_d     = 1'b0;
    valid_d     = 1'b0;
    done_d      = 1'b0;
    err_zero_d  = err_zero_q  & ~err_clr_i;
    err_multi_d = err_multi_q & ~err_clr_i;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (hot_zero) begin
            err_zero_d = 1'b1;
          end else if (hot_multi) begin
            err_multi_d = 1'b1;
          end else begin
            state_d = S_HOLD;
            idx_d   = enc_idx;
            sel_d   = hot_one_i;
            cnt_d   = (dwell_i == '0) ? '0 : dwell_i - DW_W'(1);
          end
        end
      end
      S_HOLD: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - DW_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered decodes of the next state.
    ready_d = (state_d == S_IDLE);
    valid_d = (state_d == S_HOLD);
    done_d  = (state_d == S_DONE);
    if (state_d != S_HOLD) begin
      sel_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      sel_q       <= '0;
      ready_q     <= 1'b1;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      err_zero_q  <= 1'b0;
      err_multi_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      sel_q       <= sel_d;
      ready_q     <= ready_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      err_zero_q  <= err_zero_d;
      err_multi_q <= err_multi_d;
    end
  end

  assign ready_o     = ready_q;
  assign ch_idx_o    = idx_q;
  assign ch_sel_o    = sel_q;
  assign ch_valid_o  = valid_q;
  assign ch_done_o   = done_q;
  assign err_zero_o  = err_zero_q;
  assign err_multi_o = err_multi_q;

endmodule

// File: tb/tb_onehot_ch_sequencer.sv
// Cycle-by-cycle vector table for onehot_ch_sequencer; expected outputs flow
// through a scoreboard queue from drive time to the post-edge compare.
module tb_onehot_ch_sequencer;

  localparam int unsigned N_CH  = 16;
  localparam int unsigned DW_W  = 8;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned N_VEC = 32;
  localparam int unsigned SPLIT = 25;

  typedef struct packed {
    logic              rdy;
    logic              vld;
    logic              dn;
    logic [IDX_W-1:0]  idx;
    logic [N_CH-1:0]   sel;
    logic              ez;
    logic              em;
  } exp_t;

  typedef struct packed {
    logic              v;
    logic [N_CH-1:0]   hot;
    logic [DW_W-1:0]   dw;
    logic              ab;
    logic              clr;
    exp_t              e;
  } vec_t;

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic [N_CH-1:0]        hot_one_i;
  logic                   valid_i;
  logic                   ready_o;
  logic [DW_W-1:0]        dwell_i;
  logic                   abort_i;
  logic                   err_clr_i;
  logic [IDX_W-1:0]       ch_idx_o;
  logic [N_CH-1:0]        ch_sel_o;
  logic                   ch_valid_o;
  logic                   ch_done_o;
  logic                   err_zero_o;
  logic                   err_multi_o;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  vec_t        tbl [N_VEC];
  exp_t        sb_q [$];

  onehot_ch_sequencer #(.N_CH(N_CH), .DW_W(DW_W)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .hot_one_i   (hot_one_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .dwell_i     (dwell_i),
    .abort_i     (abort_i),
    .err_clr_i   (err_clr_i),
    .ch_idx_o    (ch_idx_o),
    .ch_sel_o    (ch_sel_o),
    .ch_valid_o  (ch_valid_o),
    .ch_done_o   (ch_done_o),
    .err_zero_o  (err_zero_o),
    .err_multi_o (err_multi_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic vec_t mk(input logic v, input logic [N_CH-1:0] hot,
                              input logic [DW_W-1:0] dw, input logic ab, input logic clr,
                              input logic rdy, input logic vld, input logic dn,
                              input logic [IDX_W-1:0] idx, input logic [N_CH-1:0] sel,
                              input logic ez, input logic em);
    vec_t t;
    t.v = v; t.hot = hot; t.dw = dw; t.ab = ab; t.clr = clr;
    t.e.rdy = rdy; t.e.vld = vld; t.e.dn = dn; t.e.idx = idx;
    t.e.sel = sel; t.e.ez = ez; t.e.em = em;
    return t;
  endfunction

  task automatic cmp(input string name, input int unsigned tag,
                     input logic [N_CH-1:0] act, input logic [N_CH-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, tag, act, req);
    end
  endtask

  task automatic check_outputs(input int unsigned tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard step %0d: queue empty", tag);
      return;
    end
    e = sb_q.pop_front();
    cmp("ready_o",     tag, N_CH'(ready_o),     N_CH'(e.rdy));
    cmp("ch_valid_o",  tag, N_CH'(ch_valid_o),  N_CH'(e.vld));
    cmp("ch_done_o",   tag, N_CH'(ch_done_o),   N_CH'(e.dn));
    cmp("ch_idx_o",    tag, N_CH'(ch_idx_o),    N_CH'(e.idx));
    cmp("ch_sel_o",    tag, ch_sel_o,           e.sel);
    cmp("err_zero_o",  tag, N_CH'(err_zero_o),  N_CH'(e.ez));
    cmp("err_multi_o", tag, N_CH'(err_multi_o), N_CH'(e.em));
  endtask

  task automatic apply(input int unsigned i);
    @(negedge clk_i);
    valid_i   = tbl[i].v;
    hot_one_i = tbl[i].hot;
    dwell_i   = tbl[i].dw;
    abort_i   = tbl[i].ab;
    err_clr_i = tbl[i].clr;
    sb_q.push_back(tbl[i].e);
    @(posedge clk_i);
    #1;
    check_outputs(i);
  endtask

  initial begin
    // Columns: valid, hot, dwell, abort, clr | ready, ch_valid, done, idx, sel, err_zero, err_multi
    tbl[0]  = mk(1, 16'h0020, 8'd3,  0, 0,  0, 1, 0, 4'd5,  16'h0020, 0, 0);
    tbl[1]  = mk(0, 16'h0000, 8'd0,  0, 0,  0, 1, 0, 4'd5,  16'h0020, 0, 0);
    tbl[2]  = mk(0, 16'h0000, 8'd0,  0, 0,  0, 1, 0, 4'd5,  16'h0020, 0, 0);
    tbl[3]  = mk(0, 16'h0000, 8'd0,  0, 0,  0, 0, 1, 4'd5,  16'h0000, 0, 0);
    tbl[4]  = mk(0, 16'h0000, 8'd0,  0, 0,  1, 0, 0, 4'd5,  16'h0000, 0, 0);
    tbl[5]  = mk(1, 16'h8000, 8'd0,  0, 0,  0, 1, 0, 4'd15, 16'h8000, 0, 0);
    tbl[6]  = mk(0, 16'h0000, 8'd0,  0, 0,  0, 0, 1, 4'd15, 16'h0000, 0, 0);
    tbl[7]  = mk(0, 16'h0000, 8'd0,  0, 0,  1, 0, 0, 4'd15, 16'h0000, 0, 0);
    tbl[8]  = mk(1, 16'h0001, 8'd1,  0, 0,  0, 1, 0, 4'd0,  16'h0001, 0, 0);
    tbl[9]  = mk(1, 16'h0002, 8'd1,  0, 0,  0, 0, 1, 4'd0,  16'h0000, 0, 0);
    tbl[10] = mk(1, 16'h0002, 8'd1,  0, 0,  1, 0, 0, 4'd0,  16'h0000, 0, 0);
    tbl[11] = mk(1, 16'h0002, 8'd1,  0, 0,  0, 1, 0, 4'd1,  16'h0002, 0, 0);
    tbl[12] = mk(0, 16'h0000, 8'd0,  0, 0,  0, 0, 1, 4'd1,  16'h0000, 0, 0);
    tbl[13] = mk(0, 16'h0000, 8'd0,  0, 0,  1, 0, 0, 4'd1,  16'h0000, 0, 0);
    tbl[14] = mk(1, 16'h0000, 8'd4,  0, 0,  1, 0, 0, 4'd1,  16'h0000, 1, 0);
    tbl[15] = mk(1, 16'h0101, 8'd4,  0, 0,  1, 0, 0, 4'd1,  16'h0000, 1, 1);
    tbl[16] = mk(0, 16'h0000, 8'd0,  0, 1,  1, 0, 0, 4'd1,  16'h0000, 0, 0);
    tbl[17] = mk(1, 16'h0004, 8'd10, 0, 0,  0, 1, 0, 4'd2,  16'h0004, 0, 0);
    tbl[18] = mk(0, 16'h0000, 8'd0,  0, 0,  0, 1, 0, 4'd2,  16'h0004, 0, 0);
    tbl[19] = mk(0, 16'h0000, 8'd0,  0, 0,  0, 1, 0, 4'd2,  16'h0004, 0, 0);
    tbl[20] = mk(0, 16'h0000, 8'd0,  0, 0,  0, 1, 0, 4'd2,  16'h0004, 0, 0);
    tbl[21] = mk(0, 16'h0000, 8'd0,  1, 0,  1, 0, 0, 4'd2,  16'h0000, 0, 0);
    tbl[22] = mk(0, 16'h0000, 8'd0,  0, 0,  1, 0, 0, 4'd2,  16'h0000, 0, 0);
    tbl[23] = mk(1, 16'h0004, 8'd5,  0, 0,  0, 1, 0, 4'd2,  16'h0004, 0, 0);
    tbl[24] = mk(1, 16'h0002, 8'd5,  0, 0,  0, 1, 0, 4'd2,  16'h0004, 0, 0);
    tbl[25] = mk(1, 16'h0000, 8'd0,  0, 0,  1, 0, 0, 4'd0,  16'h0000, 1, 0);
    tbl[26] = mk(1, 16'h0003, 8'd0,  0, 1,  1, 0, 0, 4'd0,  16'h0000, 0, 1);
    tbl[27] = mk(0, 16'h0000, 8'd0,  1, 0,  1, 0, 0, 4'd0,  16'h0000, 0, 1);
    tbl[28] = mk(1, 16'h0008, 8'd2,  0, 1,  0, 1, 0, 4'd3,  16'h0008, 0, 0);
    tbl[29] = mk(0, 16'h0000, 8'd0,  0, 0,  0, 1, 0, 4'd3,  16'h0008, 0, 0);
    tbl[30] = mk(0, 16'h0000, 8'd0,  0, 0,  0, 0, 1, 4'd3,  16'h0000, 0, 0);
    tbl[31] = mk(0, 16'h0000, 8'd0,  0, 0,  1, 0, 0, 4'd3,  16'h0000, 0, 0);

    rst_i     = 1'b1;
    valid_i   = 1'b0;
    hot_one_i = '0;
    dwell_i   = '0;
    abort_i   = 1'b0;
    err_clr_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    sb_q.push_back(mk(0, 16'h0, 8'd0, 0, 0, 1, 0, 0, 4'd0, 16'h0, 0, 0).e);
    check_outputs(1000);
    @(negedge clk_i);
    rst_i = 1'b0;

    for (int unsigned i = 0; i < SPLIT; i++) begin
      apply(i);
    end

    // Mid-HOLD reset must clear outputs between clock edges.
    #2;
    rst_i = 1'b1;
    sb_q.push_back(mk(0, 16'h0, 8'd0, 0, 0, 1, 0, 0, 4'd0, 16'h0, 0, 0).e);
    #1;
    check_outputs(2000);
    valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;

    for (int unsigned i = SPLIT; i < N_VEC; i++) begin
      apply(i);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
